// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one byte-wide synchronous memory port between the cpu and a loader/debug DMA.
// Optional feature macro ARB_BURST_LOCK_EN: honour pN_lock so an owner may keep the grant for up to MAX_BURST beats.
module mem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic          p0_we,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic          p1_we,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [AW-1:0] r_addr_hold;
  logic [DW-1:0] r_wdata_hold;
  logic          r_p0_rvalid;
  logic          r_p1_rvalid;

  logic          w_own_req;
  logic          w_own_we;
  logic          w_oth_req;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;
  logic          w_beat;
  logic          w_keep;
  logic          w_release;

  // Owner/other view of the two ports, selected by the current grant
  always_comb begin
    w_own_req   = 1'b0;
    w_own_we    = 1'b0;
    w_oth_req   = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    case (r_state)
      ST_G0: begin
        w_own_req   = p0_req;
        w_own_we    = p0_we;
        w_oth_req   = p1_req;
        w_own_addr  = p0_addr;
        w_own_wdata = p0_wdata;
      end
      ST_G1: begin
        w_own_req   = p1_req;
        w_own_we    = p1_we;
        w_oth_req   = p0_req;
        w_own_addr  = p1_addr;
        w_own_wdata = p1_wdata;
      end
      default: ;
    endcase
  end

  assign w_beat = w_own_req;

`ifdef ARB_BURST_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  logic          w_own_lock;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  assign w_own_lock = (r_state == ST_G1) ? p1_lock : p0_lock;

  // Saturating beat count of the current grant; a locked owner yields once it reaches MAX_BURST-1
  assign w_keep = w_own_lock && (r_count < CW'(MAX_BURST - 1));

  always_comb begin
    w_count_nxt = r_count;
    if (w_state_nxt != r_state) begin
      w_count_nxt = '0;
    end else if (w_beat && (r_count < CW'(MAX_BURST - 1))) begin
      w_count_nxt = r_count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = p0_lock | p1_lock;
  assign w_keep        = 1'b0;
`endif

  // An uncontended owner keeps the grant; contention after a beat hands it over unless the burst may continue
  assign w_release = (r_state == ST_NONE) || !w_own_req || (w_beat && w_oth_req && !w_keep);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    if (w_release) begin
      if (p0_req && p1_req) begin
        w_state_nxt = r_last ? ST_G0 : ST_G1;
      end else if (p0_req) begin
        w_state_nxt = ST_G0;
      end else if (p1_req) begin
        w_state_nxt = ST_G1;
      end else begin
        w_state_nxt = ST_NONE;
      end
    end
    if (w_state_nxt == ST_G0) begin
      w_last_nxt = 1'b0;
    end else if (w_state_nxt == ST_G1) begin
      w_last_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant history, idle address/data hold and per-port read strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_p0_rvalid  <= 1'b0;
      r_p1_rvalid  <= 1'b0;
    end else begin
      r_last      <= w_last_nxt;
      r_p0_rvalid <= w_beat && !w_own_we && (r_state == ST_G0);
      r_p1_rvalid <= w_beat && !w_own_we && (r_state == ST_G1);
      if (w_beat) begin
        r_addr_hold  <= w_own_addr;
        r_wdata_hold <= w_own_wdata;
      end
    end
  end

  assign p0_gnt    = (r_state == ST_G0);
  assign p1_gnt    = (r_state == ST_G1);
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

  assign mem_we    = w_beat && w_own_we;
  assign mem_addr  = w_beat ? w_own_addr : r_addr_hold;
  assign mem_wdata = w_beat ? w_own_wdata : r_wdata_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed latency/ordering scenarios plus randomized two-port traffic.
module tb_mem_arbiter;
  localparam int unsigned AW        = 16;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;
`ifdef ARB_BURST_LOCK_EN
  localparam int STREAK_MAX = MAX_BURST;
  localparam bit LOCK_ON    = 1'b1;
`else
  localparam int STREAK_MAX = 1;
  localparam bit LOCK_ON    = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          p0_req, p0_lock, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_lock, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment RAM: synchronous, one-cycle read latency
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference memory: initial contents are a fixed function of the address, overlaid by observed writes
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   log_port[$];
  int   log_cyc[$];
  int   we_cycles = 0;
  int   rv1_cnt   = 0;
  int   streak    = 0;
  int   streak_port = 0;

  // Monitor: checks memory-side beats, scoreboards read returns, bounds contended bursts
  initial forever begin : mon
    exp_t        e;
    logic        b0, b1, bw, orq;
    int          bp;
    logic [15:0] ba;
    logic [7:0]  bd;
    @(negedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      streak = 0;
    end else begin
      chk("gnt_exclusive", 32'(p0_gnt & p1_gnt), 32'd0);
      if (mem_we) we_cycles++;
      if (p0_rvalid) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL p0_rvalid_unexpected: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q0.pop_front();
          chk("p0_rdata", 32'(p0_rdata), 32'(e.d));
          chk("p0_rvalid_cycle", cyc, e.due);
        end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
        n_cmp++; n_err++;
        $display("FAIL p0_rvalid_missing: got 0 expected 1 at cycle %0d", cyc);
        void'(q0.pop_front());
      end
      if (p1_rvalid) begin
        rv1_cnt++;
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL p1_rvalid_unexpected: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          chk("p1_rdata", 32'(p1_rdata), 32'(e.d));
          chk("p1_rvalid_cycle", cyc, e.due);
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        n_cmp++; n_err++;
        $display("FAIL p1_rvalid_missing: got 0 expected 1 at cycle %0d", cyc);
        void'(q1.pop_front());
      end
      b0 = p0_req & p0_gnt;
      b1 = p1_req & p1_gnt;
      if (b0 || b1) begin
        bp  = b1 ? 1 : 0;
        ba  = b1 ? p1_addr : p0_addr;
        bw  = b1 ? p1_we : p0_we;
        bd  = b1 ? p1_wdata : p0_wdata;
        orq = b1 ? p0_req : p1_req;
        chk("mem_addr", 32'(mem_addr), 32'(ba));
        chk("mem_we", 32'(mem_we), 32'(bw));
        if (bw) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(bd));
          ref_mem[ba] = bd;
        end else begin
          e.d   = ref_rd(ba);
          e.due = cyc + 1;
          if (bp == 0) q0.push_back(e);
          else         q1.push_back(e);
        end
        log_port.push_back(bp);
        log_cyc.push_back(cyc);
        if (orq) begin
          if (streak_port == bp) streak++;
          else begin
            streak_port = bp;
            streak = 1;
          end
          chk("burst_limit", 32'(streak <= STREAK_MAX), 32'd1);
        end else begin
          streak = 0;
        end
      end else begin
        chk("mem_we_idle", 32'(mem_we), 32'd0);
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic we, input logic [15:0] a,
                          input logic [7:0] d, input logic lk);
    if (p == 0) begin
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; p0_lock = lk;
    end else begin
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lk;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns one step after the accepting edge
  task automatic xact(input int p, input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic lk);
    bit done;
    done = 1'b0;
    set_port(p, 1'b1, we, a, d, lk);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = (p == 0) ? p0_gnt : p1_gnt;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL xact_timeout port%0d: got no grant expected grant within 64 cycles", p);
    end
    tick();
  endtask

  task automatic rand_gap(input int p);
    int n;
    n = $urandom_range(0, 2);
    if (n > 0) begin
      set_port(p, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      repeat (n) tick();
    end
  endtask

  task automatic do_reset();
    set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Compare the logged beat sequence with a bit pattern (bit i = port of beat i), expecting no idle gaps
  task automatic check_log(input string name, input logic [15:0] pat, input int n);
    chk({name, "_len"}, log_port.size(), n);
    for (int i = 0; i < n && i < log_port.size(); i++) begin
      chk($sformatf("%s_port%0d", name, i), log_port[i], 32'(pat[i]));
      if (i > 0) chk($sformatf("%s_gap%0d", name, i), log_cyc[i] - log_cyc[i-1], 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    ram[16'h0010]     = 8'hA5;
    ref_mem[16'h0010] = 8'hA5;
    set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Single read: grant one cycle after request, data one cycle after the beat
    set_port(0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
    @(negedge clk);
    chk("single_gnt_n", 32'(p0_gnt), 32'd0);
    @(negedge clk);
    chk("single_gnt_n1", 32'(p0_gnt), 32'd1);
    chk("single_addr_n1", 32'(mem_addr), 32'h0010);
    tick();
    set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    @(negedge clk);
    chk("single_rvalid_n2", 32'(p0_rvalid), 32'd1);
    chk("single_rdata_n2", 32'(p0_rdata), 32'hA5);
    tick(); tick();

    // Contention from reset with lock low: p0 first, then strict alternation
    do_reset();
    log_port.delete(); log_cyc.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) xact(0, 1'b0, 16'h0020 + 16'(i), 8'h00, 1'b0);
        set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) xact(1, 1'b0, 16'h0020 + 16'(i), 8'h00, 1'b0);
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
    join
    tick(); tick();
    check_log("contend", 16'b101010, 6);

    // Locked 4-beat burst from p0 while p1 keeps requesting
    do_reset();
    log_port.delete(); log_cyc.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) xact(0, 1'b0, 16'h0100 + 16'(i), 8'h00, 1'b1);
        set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) xact(1, 1'b0, 16'h0180 + 16'(i), 8'h00, 1'b0);
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
    join
    tick(); tick();
    if (LOCK_ON) check_log("burst", 16'b1110000, 7);
    else         check_log("burst", 16'b0101010, 7);

    // Write then read back on p1
    we_cycles = 0;
    rv1_cnt   = 0;
    xact(1, 1'b1, 16'h00FF, 8'h3C, 1'b0);
    xact(1, 1'b0, 16'h00FF, 8'h00, 1'b0);
    set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick(); tick();
    chk("wr_we_cycles", we_cycles, 1);
    chk("wr_p1_rvalid_count", rv1_cnt, 1);

    // Reset in the middle of a locked burst; the write beat pending at reset must not land
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst_gnt_before", 32'(p0_gnt), 32'd1);
    chk("midrst_rvalid_before", 32'(p0_rvalid), 32'd1);
    set_port(0, 1'b1, 1'b1, 16'h0200, 8'h77, 1'b1);
    #1;
    chk("midrst_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(p0_gnt), 32'd0);
    chk("midrst_rvalid", 32'(p0_rvalid), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    set_port(0, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0);
    @(negedge clk);
    chk("rereq_gnt_n", 32'(p0_gnt), 32'd0);
    @(negedge clk);
    chk("rereq_gnt_n1", 32'(p0_gnt), 32'd1);
    tick();
    set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();

    // Randomized traffic on a small shared address window
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          rand_gap(0);
          xact(0, ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 31)), 8'($urandom),
               1'($urandom));
        end
        set_port(0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 150; i++) begin
          rand_gap(1);
          xact(1, ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 31)), 8'($urandom),
               1'($urandom));
        end
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      end
    join
    repeat (4) tick();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
